// File: rtl/pong_pkg.sv
// Shared types and defaults for the pong game controller: state and player
// encodings, BCD digit width and the two-digit BCD increment helper.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_SERVE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    typedef enum logic {
        PL_L = 1'b0,
        PL_R = 1'b1
    } player_t;

    localparam int         BCD_DIG_W       = 4;
    localparam logic [7:0] WIN_SCORE_DEF   = 8'h07;
    localparam int         SERVE_TICKS_DEF = 120;

    // Two-digit BCD +1, saturating at 99.
    function automatic logic [2*BCD_DIG_W-1:0] bcd2_inc(input logic [2*BCD_DIG_W-1:0] v);
        logic [BCD_DIG_W-1:0] tens;
        logic [BCD_DIG_W-1:0] units;
        tens  = v[2*BCD_DIG_W-1:BCD_DIG_W];
        units = v[BCD_DIG_W-1:0];
        if (v == 8'h99) begin
            return v;
        end
        if (units == 4'd9) begin
            return {tens + 4'd1, 4'd0};
        end
        return {tens, units + 4'd1};
    endfunction

endpackage

// File: rtl/pong_if.sv
// Signal bundle between the game controller and the graphics/input side.
// Carries rally_cnt only when PONG_RALLY_CNT_EN is defined.
interface pong_if;
    logic       timer_tick;
    logic       btn_start;
    logic       miss;
    logic       hit_left;
    logic       hit_right;
    logic       graph_still;
    logic [7:0] score_l;
    logic [7:0] score_r;
    logic       game_over;
    logic       winner;
`ifdef PONG_RALLY_CNT_EN
    logic [7:0] rally_cnt;
`endif

    modport master (
        input  timer_tick, btn_start, miss, hit_left, hit_right,
`ifdef PONG_RALLY_CNT_EN
        output rally_cnt,
`endif
        output graph_still, score_l, score_r, game_over, winner
    );

    modport slave (
        output timer_tick, btn_start, miss, hit_left, hit_right,
`ifdef PONG_RALLY_CNT_EN
        input  rally_cnt,
`endif
        input  graph_still, score_l, score_r, game_over, winner
    );
endinterface

// File: rtl/pong_bcd2_cnt.sv
// Two-digit BCD counter with synchronous clear, increment and saturation at 99.
module bcd2_cnt
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] q
);
    logic [7:0] q_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_reg <= 8'h00;
        end else if (clr) begin
            q_reg <= 8'h00;
        end else if (inc) begin
            q_reg <= bcd2_inc(q_reg);
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game controller: scores, serve delay and game-over sequencing.
// Optional rally counter output is enabled with PONG_RALLY_CNT_EN.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter logic [7:0] WIN_SCORE   = WIN_SCORE_DEF,
    parameter int         SERVE_TICKS = SERVE_TICKS_DEF,
    parameter int         TMR_W       = 8
)(
    input  logic  clk,
    input  logic  reset_n,
    pong_if.master bus
);
    state_t             state_reg, state_next;
    player_t            last_hitter_reg, last_hitter_next;
    player_t            winner_reg, winner_next;
    player_t            lh_eff;
    logic [TMR_W-1:0]   timer_reg, timer_next;
    logic               start_d_reg, hit_l_d_reg, hit_r_d_reg;
    logic               start_p, hit_l_p, hit_r_p;
    logic               clr_scores, inc_l, inc_r;
    logic [7:0]         score_l_q, score_r_q, scored;

    assign start_p = bus.btn_start & ~start_d_reg;
    assign hit_l_p = bus.hit_left  & ~hit_l_d_reg;
    assign hit_r_p = bus.hit_right & ~hit_r_d_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            last_hitter_reg <= PL_L;
            winner_reg      <= PL_L;
            timer_reg       <= '0;
            start_d_reg     <= 1'b0;
            hit_l_d_reg     <= 1'b0;
            hit_r_d_reg     <= 1'b0;
        end else begin
            state_reg       <= state_next;
            last_hitter_reg <= last_hitter_next;
            winner_reg      <= winner_next;
            timer_reg       <= timer_next;
            start_d_reg     <= bus.btn_start;
            hit_l_d_reg     <= bus.hit_left;
            hit_r_d_reg     <= bus.hit_right;
        end
    end

    always_comb begin
        state_next       = state_reg;
        last_hitter_next = last_hitter_reg;
        winner_next      = winner_reg;
        timer_next       = timer_reg;
        clr_scores       = 1'b0;
        inc_l            = 1'b0;
        inc_r            = 1'b0;
        lh_eff           = last_hitter_reg;
        scored           = score_l_q;
        case (state_reg)
            ST_IDLE: begin
                if (start_p) begin
                    clr_scores       = 1'b1;
                    last_hitter_next = PL_L;
                    state_next       = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Simultaneous left+right edges leave the hitter unchanged.
                if (hit_l_p && !hit_r_p) begin
                    lh_eff = PL_L;
                end else if (hit_r_p && !hit_l_p) begin
                    lh_eff = PL_R;
                end
                last_hitter_next = lh_eff;
                if (bus.miss) begin
                    scored           = (lh_eff == PL_L) ? score_l_q : score_r_q;
                    inc_l            = (lh_eff == PL_L);
                    inc_r            = (lh_eff == PL_R);
                    last_hitter_next = PL_L;
                    if (bcd2_inc(scored) == WIN_SCORE) begin
                        state_next  = ST_OVER;
                        winner_next = lh_eff;
                    end else begin
                        state_next = ST_SERVE;
                        timer_next = TMR_W'(SERVE_TICKS);
                    end
                end
            end
            ST_SERVE: begin
                if (bus.timer_tick) begin
                    if (timer_reg <= TMR_W'(1)) begin
                        timer_next = '0;
                        state_next = ST_PLAY;
                    end else begin
                        timer_next = timer_reg - TMR_W'(1);
                    end
                end
            end
            ST_OVER: begin
                if (start_p) begin
                    clr_scores       = 1'b1;
                    last_hitter_next = PL_L;
                    timer_next       = TMR_W'(SERVE_TICKS);
                    state_next       = ST_SERVE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    bcd2_cnt u_score_l (.clk(clk), .reset_n(reset_n), .clr(clr_scores), .inc(inc_l), .q(score_l_q));
    bcd2_cnt u_score_r (.clk(clk), .reset_n(reset_n), .clr(clr_scores), .inc(inc_r), .q(score_r_q));

`ifdef PONG_RALLY_CNT_EN
    logic rally_clr, rally_inc;
    // Cleared whenever a serve (or a fresh game) begins; kept through OVER.
    assign rally_clr = ((state_next == ST_SERVE) && (state_reg != ST_SERVE)) ||
                       ((state_reg == ST_IDLE) && (state_next == ST_PLAY));
    assign rally_inc = (state_reg == ST_PLAY) && (hit_l_p || hit_r_p);
    bcd2_cnt u_rally (.clk(clk), .reset_n(reset_n), .clr(rally_clr), .inc(rally_inc), .q(bus.rally_cnt));
`endif

    assign bus.graph_still = (state_reg != ST_PLAY);
    assign bus.game_over   = (state_reg == ST_OVER);
    assign bus.winner      = winner_reg;
    assign bus.score_l     = score_l_q;
    assign bus.score_r     = score_r_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl, built with WIN_SCORE=8'h10 and 120 serve ticks.
module tb_pong_game_ctrl;
    logic clk;
    logic reset_n;
    int   checks;
    int   fails;

    pong_if bus();

    pong_game_ctrl #(.WIN_SCORE(8'h10), .SERVE_TICKS(120), .TMR_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.timer_tick = 1'b1;
            step();
            bus.timer_tick = 1'b0;
            step();
        end
    endtask

    task automatic pulse_hit(input logic l, input logic r);
        bus.hit_left  = l;
        bus.hit_right = r;
        step();
        bus.hit_left  = 1'b0;
        bus.hit_right = 1'b0;
        step();
    endtask

    // 119 ticks must keep the ball frozen, the 120th must release it.
    task automatic serve_check(input string nm);
        tick_n(119);
        checks++;
        if (bus.graph_still !== 1'b1) begin
            fails++;
            $display("FAIL %s_119: graph_still=%0b want 1", nm, bus.graph_still);
        end
        tick_n(1);
        checks++;
        if (bus.graph_still !== 1'b0) begin
            fails++;
            $display("FAIL %s_120: graph_still=%0b want 0", nm, bus.graph_still);
        end
        $display("serve %s: graph_still=%0b", nm, bus.graph_still);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++;
        if (bus.graph_still !== 1'b1) begin fails++; $display("FAIL reset_still: got %0b want 1", bus.graph_still); end
        checks++;
        if (bus.score_l !== 8'h00 || bus.score_r !== 8'h00) begin
            fails++; $display("FAIL reset_scores: got %h/%h want 00/00", bus.score_l, bus.score_r);
        end
        checks++;
        if (bus.game_over !== 1'b0 || bus.winner !== 1'b0) begin
            fails++; $display("FAIL reset_over: got over=%0b winner=%0b want 0/0", bus.game_over, bus.winner);
        end
        reset_n = 1'b1;
        step();
        $display("reset: still=%0b scores=%h/%h", bus.graph_still, bus.score_l, bus.score_r);
    endtask

    task automatic test_start();
        bus.btn_start = 1'b1;
        checks++;
        if (bus.graph_still !== 1'b1) begin fails++; $display("FAIL start_pre: got %0b want 1", bus.graph_still); end
        step();
        checks++;
        if (bus.graph_still !== 1'b0) begin fails++; $display("FAIL start_play: got %0b want 0", bus.graph_still); end
        step(); step(); step();
        checks++;
        if (bus.graph_still !== 1'b0 || bus.score_l !== 8'h00 || bus.score_r !== 8'h00) begin
            fails++; $display("FAIL start_hold: still=%0b scores=%h/%h want 0 00/00", bus.graph_still, bus.score_l, bus.score_r);
        end
        bus.btn_start = 1'b0;
        step();
        $display("start: still=%0b", bus.graph_still);
    endtask

    task automatic test_miss_hold();
        bus.hit_right = 1'b1;
        step();
        bus.hit_right = 1'b0;
        bus.miss      = 1'b1;
        step();
        checks++;
        if (bus.score_r !== 8'h01 || bus.graph_still !== 1'b1) begin
            fails++; $display("FAIL miss_score: score_r=%h still=%0b want 01 1", bus.score_r, bus.graph_still);
        end
        step(); step(); step(); step();
        checks++;
        if (bus.score_r !== 8'h01 || bus.score_l !== 8'h00) begin
            fails++; $display("FAIL miss_once: scores=%h/%h want 00/01", bus.score_l, bus.score_r);
        end
        bus.miss = 1'b0;
        step();
        $display("miss_hold: scores=%h/%h", bus.score_l, bus.score_r);
        serve_check("miss");
    endtask

    task automatic test_simultaneous();
        pulse_hit(1'b0, 1'b1);
        bus.hit_left = 1'b1;
        bus.miss     = 1'b1;
        step();
        checks++;
        if (bus.score_l !== 8'h01 || bus.score_r !== 8'h01) begin
            fails++; $display("FAIL hit_miss: scores=%h/%h want 01/01", bus.score_l, bus.score_r);
        end
        bus.hit_left = 1'b0;
        bus.miss     = 1'b0;
        step();
        $display("hit_miss: scores=%h/%h", bus.score_l, bus.score_r);
        serve_check("hm");
        pulse_hit(1'b0, 1'b1);
        pulse_hit(1'b1, 1'b1);
        bus.miss = 1'b1;
        step();
        checks++;
        if (bus.score_r !== 8'h02 || bus.score_l !== 8'h01) begin
            fails++; $display("FAIL both_hits: scores=%h/%h want 01/02", bus.score_l, bus.score_r);
        end
        bus.miss = 1'b0;
        step();
        $display("both_hits: scores=%h/%h", bus.score_l, bus.score_r);
        serve_check("bh");
    endtask

    task automatic test_bcd_carry();
        for (int i = 0; i < 8; i++) begin
            bus.miss = 1'b1;
            step();
            bus.miss = 1'b0;
            step();
            tick_n(120);
        end
        checks++;
        if (bus.score_l !== 8'h09 || bus.graph_still !== 1'b0) begin
            fails++; $display("FAIL pre_carry: score_l=%h still=%0b want 09 0", bus.score_l, bus.graph_still);
        end
        bus.miss = 1'b1;
        step();
        checks++;
        if (bus.score_l !== 8'h10) begin fails++; $display("FAIL carry: score_l=%h want 10", bus.score_l); end
        checks++;
        if (bus.game_over !== 1'b1 || bus.winner !== 1'b0 || bus.graph_still !== 1'b1) begin
            fails++; $display("FAIL over: over=%0b winner=%0b still=%0b want 1 0 1", bus.game_over, bus.winner, bus.graph_still);
        end
        step(); step(); step();
        checks++;
        if (bus.score_l !== 8'h10 || bus.score_r !== 8'h02 || bus.game_over !== 1'b1) begin
            fails++; $display("FAIL over_hold: scores=%h/%h over=%0b want 10/02 1", bus.score_l, bus.score_r, bus.game_over);
        end
        bus.miss = 1'b0;
        step();
        $display("carry: scores=%h/%h over=%0b", bus.score_l, bus.score_r, bus.game_over);
    endtask

    task automatic test_restart();
        bus.btn_start  = 1'b1;
        bus.timer_tick = 1'b1;
        step();
        bus.timer_tick = 1'b0;
        checks++;
        if (bus.score_l !== 8'h00 || bus.score_r !== 8'h00 || bus.game_over !== 1'b0 || bus.graph_still !== 1'b1) begin
            fails++; $display("FAIL restart: scores=%h/%h over=%0b still=%0b want 00/00 0 1",
                              bus.score_l, bus.score_r, bus.game_over, bus.graph_still);
        end
        serve_check("restart");
        bus.btn_start = 1'b0;
        step();
        bus.btn_start = 1'b1;
        step(); step();
        checks++;
        if (bus.graph_still !== 1'b0 || bus.game_over !== 1'b0) begin
            fails++; $display("FAIL btn_in_play: still=%0b over=%0b want 0 0", bus.graph_still, bus.game_over);
        end
        bus.btn_start = 1'b0;
        step();
        pulse_hit(1'b1, 1'b0);
        pulse_hit(1'b0, 1'b1);
        pulse_hit(1'b1, 1'b0);
`ifdef PONG_RALLY_CNT_EN
        checks++;
        if (bus.rally_cnt !== 8'h03) begin fails++; $display("FAIL rally: got %h want 03", bus.rally_cnt); end
`endif
        bus.miss = 1'b1;
        step();
        bus.miss = 1'b0;
        checks++;
        if (bus.score_l !== 8'h01 || bus.graph_still !== 1'b1) begin
            fails++; $display("FAIL rally_miss: score_l=%h still=%0b want 01 1", bus.score_l, bus.graph_still);
        end
`ifdef PONG_RALLY_CNT_EN
        checks++;
        if (bus.rally_cnt !== 8'h00) begin fails++; $display("FAIL rally_clr: got %h want 00", bus.rally_cnt); end
`endif
        step();
        $display("restart: scores=%h/%h", bus.score_l, bus.score_r);
        serve_check("rally");
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.graph_still !== 1'b1 || bus.game_over !== 1'b0) begin
            fails++; $display("FAIL async_rst: still=%0b over=%0b want 1 0", bus.graph_still, bus.game_over);
        end
        checks++;
        if (bus.score_l !== 8'h00 || bus.score_r !== 8'h00) begin
            fails++; $display("FAIL async_rst_scores: got %h/%h want 00/00", bus.score_l, bus.score_r);
        end
        step();
        reset_n = 1'b1;
        step();
        $display("async_reset: still=%0b scores=%h/%h", bus.graph_still, bus.score_l, bus.score_r);
    endtask

    initial begin
        checks         = 0;
        fails          = 0;
        reset_n        = 1'b0;
        bus.timer_tick = 1'b0;
        bus.btn_start  = 1'b0;
        bus.miss       = 1'b0;
        bus.hit_left   = 1'b0;
        bus.hit_right  = 1'b0;
        test_reset();
        test_start();
        test_miss_hold();
        test_simultaneous();
        test_bcd_carry();
        test_restart();
        test_async_reset();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
